mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Owns the instruction register (IR) and drives the imm_gen type select, ALU/writeback/PC muxes and register-file write enable.
- Issues request/ack handshakes to instruction and data memory.
- Sits between the memory interfaces and the datapath (imm_gen, ALU, regfile, PC register).

Parameters:
- MEM_TIMEOUT, 255, max cycles a memory request may wait for ack (used only with the optional feature).
- XLEN, 32, instruction/IR width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- imem_req_o  out  1  instruction fetch request
- imem_ack_i  in  1  fetch data valid on instr_w_i
- instr_w_i  in  32  fetched instruction
- instr_r_o  out  32  latched IR, feeds imm_gen and regfile addresses
- imm_sel_o  out  3  immediate type: 0 none, 1 J, 2 U, 3 S, 4 B, 5 I
- alu_op_o  out  2  0 add, 1 funct-driven, 2 compare, 3 pass-imm
- alu_a_sel_o  out  1  0 rs1, 1 PC
- alu_b_sel_o  out  1  0 rs2, 1 imm
- branch_taken_i  in  1  comparator result for the current branch
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  store strobe, valid with dmem_req_o
- dmem_ack_i  in  1  data access complete
- rf_we_o  out  1  register-file write
- wb_sel_o  out  2  0 ALU, 1 mem, 2 PC+4
- pc_we_o  out  1  PC update
- pc_sel_o  out  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1
- halted_o  out  1  core stopped in TRAP
- illegal_o  out  1  halt cause was an illegal opcode
- instret_o  out  32  instructions retired

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - State is RST; IR, instret_o, illegal_o are 0; every output is 0.
  - RST always moves to FETCH on the next cycle.
- FETCH:
  - imem_req_o=1, held until imem_ack_i.
  - On the ack cycle, IR latches instr_w_i and the FSM moves to DECODE.
- DECODE (1 cycle):
  - imm_sel_o from IR[6:0]: JALR/LOAD/OP-IMM→I, STORE→S, BRANCH→B, LUI/AUIPC→U, JAL→J, OP→0.
  - FENCE is treated as NOP.
  - SYSTEM (1110011) → TRAP with illegal_o=0.
  - Any other opcode, or IR[1:0]!=2'b11 → TRAP with illegal_o=1.
- imm_sel_o is held from DECODE through the last cycle of the instruction, then returns to 0 in FETCH.
- EXEC (1 cycle), per opcode:
  - BRANCH: alu_op=2; pc_we_o=1; pc_sel=1 if branch_taken_i else 0; retire; → FETCH.
  - LOAD/STORE: alu_op=0, b_sel=1; → MEM.
  - OP/OP-IMM: alu_op=1.
  - LUI: alu_op=3.
  - AUIPC: a_sel=1, b_sel=1, alu_op=0.
  - All others (OP, OP-IMM, LUI, AUIPC, JAL, JALR, FENCE) → WB.
- MEM:
  - dmem_req_o=1 (dmem_we_o=1 for STORE), held with a stable ALU address until dmem_ack_i.
  - On ack: STORE → pc_we_o=1, pc_sel=0, retire, → FETCH. LOAD → WB.
- WB (1 cycle):
  - rf_we_o=1 unless rd=IR[11:7]==0 or opcode is FENCE.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_we_o=1 with pc_sel: 1 JAL, 2 JALR, else 0.
  - Retire; → FETCH.
- Retire: instret_o increments by 1 on the retiring cycle and wraps 0xFFFFFFFF→0.
- TRAP:
  - halted_o=1, all strobes 0.
  - Absorbing; only rst_i exits.
- Reset mid-handshake: request drops asynchronously; an ack arriving on the first cycle after reset is ignored (state RST).
- An ack arriving without an outstanding request is ignored.

Optional Feature:
- Macro: MC_CTRL_MEM_TIMEOUT_EN.
- With the macro defined:
  - An 8..32-bit wait counter clears on entry to FETCH/MEM and counts each cycle the request is unacknowledged.
  - Reaching MEM_TIMEOUT → TRAP, adding output bus_err_o=1 (reset 0).
- Without the macro: no counter, no bus_err_o; the FSM waits indefinitely.

Decomposition:
- Shared package: opcode constants, imm type codes (J=1,U=2,S=3,B=4,I=5, matching imm_gen), alu_op/wb_sel/pc_sel encodings, FSM state encoding.
- Natural sub-module: mc_ctrl_decode, a combinational opcode → {imm_sel, class, legal} decoder reusable by the bench.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with ack 2 cycles after req:
  - Requires FETCH→DECODE→EXEC→WB.
  - imm_sel=5; rf_we=1 in WB; pc_sel=0; instret 0→1.
- BEQ 0x00000463 with branch_taken_i=1:
  - pc_we=1 and pc_sel=1 in EXEC; no rf_we; imm_sel=4; back to FETCH in 4 cycles.
- SW 0x00112223:
  - dmem_req=dmem_we=1 held for 3 stall cycles until ack.
  - Retire on the ack cycle; rf_we never asserted.
- LW to rd=x0 (0x00002003): wb_sel=1 but rf_we=0; instret still increments.
- Illegal 0x0000007F → TRAP: halted_o=1, illegal_o=1; further acks ignored. ECALL 0x00000073 → halted_o=1, illegal_o=0.
- With MC_CTRL_MEM_TIMEOUT_EN and MEM_TIMEOUT=4: fetch with no ack → bus_err_o=1 and TRAP after 4 wait cycles. Assert rst_i mid-fetch → all outputs 0 immediately.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: opcodes, immediate
// types (matching imm_gen), ALU/writeback/PC mux codes, instruction classes, FSM states.
package mc_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_J    = 3'd1;
    localparam logic [2:0] IMM_U    = 3'd2;
    localparam logic [2:0] IMM_S    = 3'd3;
    localparam logic [2:0] IMM_B    = 3'd4;
    localparam logic [2:0] IMM_I    = 3'd5;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_FUNCT = 2'd1;
    localparam logic [1:0] ALU_CMP   = 2'd2;
    localparam logic [1:0] ALU_PASS  = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    typedef enum logic [3:0] {
        CL_OP,
        CL_OPIMM,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_FENCE,
        CL_SYSTEM,
        CL_ILLEGAL
    } op_class_t;

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: opcode -> immediate type, instruction class, legality.
// Every legal opcode ends in 2'b11, so a bad IR[1:0] falls into the illegal default.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output op_class_t  cls,
    output logic       legal
);

    always_comb begin
        imm_sel = IMM_NONE;
        cls     = CL_ILLEGAL;
        legal   = 1'b1;
        case (opcode)
            OPC_LUI:    begin imm_sel = IMM_U; cls = CL_LUI;    end
            OPC_AUIPC:  begin imm_sel = IMM_U; cls = CL_AUIPC;  end
            OPC_JAL:    begin imm_sel = IMM_J; cls = CL_JAL;    end
            OPC_JALR:   begin imm_sel = IMM_I; cls = CL_JALR;   end
            OPC_BRANCH: begin imm_sel = IMM_B; cls = CL_BRANCH; end
            OPC_LOAD:   begin imm_sel = IMM_I; cls = CL_LOAD;   end
            OPC_STORE:  begin imm_sel = IMM_S; cls = CL_STORE;  end
            OPC_OPIMM:  begin imm_sel = IMM_I; cls = CL_OPIMM;  end
            OPC_OP:     cls = CL_OP;
            OPC_FENCE:  cls = CL_FENCE;
            OPC_SYSTEM: cls = CL_SYSTEM;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control sequencer (IR, FSM, memory handshakes, retire count).
// Define MC_CTRL_MEM_TIMEOUT_EN to add a memory wait timeout that traps with bus_err_o.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] instr_w_i,
    output logic [XLEN-1:0] instr_r_o,
    output logic [2:0]      imm_sel_o,
    output logic [1:0]      alu_op_o,
    output logic            alu_a_sel_o,
    output logic            alu_b_sel_o,
    input  logic            branch_taken_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    input  logic            dmem_ack_i,
    output logic            rf_we_o,
    output logic [1:0]      wb_sel_o,
    output logic            pc_we_o,
    output logic [1:0]      pc_sel_o,
    output logic            halted_o,
    output logic            illegal_o,
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    output logic            bus_err_o,
`endif
    output logic [31:0]     instret_o
);

    state_t     state;
    logic [6:0] dec_opc;
    logic [2:0] dec_imm;
    op_class_t  dec_cls;
    logic       dec_legal;
    logic       rd_nz;
    logic       retire;

    // In FETCH the decoder looks at the incoming word so imm_sel is ready in DECODE.
    assign dec_opc = (state == S_FETCH) ? instr_w_i[6:0] : instr_r_o[6:0];
    assign rd_nz   = |instr_r_o[11:7];

    mc_ctrl_decode u_decode (
        .opcode  (dec_opc),
        .imm_sel (dec_imm),
        .cls     (dec_cls),
        .legal   (dec_legal)
    );

`ifdef MC_CTRL_MEM_TIMEOUT_EN
    localparam int TO_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 32) ? 32 : TO_RAW);

    logic [TO_W-1:0] wait_cnt;
    logic            wait_expired;

    assign wait_expired = (wait_cnt == TO_W'(MEM_TIMEOUT - 1));
`endif

    // PC write and select follow the live branch/ack inputs; the PC update cycle is
    // exactly the retiring cycle of every instruction.
    always_comb begin
        pc_we_o  = 1'b0;
        pc_sel_o = PC_PLUS4;
        case (state)
            S_EXEC: begin
                if (dec_cls == CL_BRANCH) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = branch_taken_i ? PC_REL : PC_PLUS4;
                end
            end
            S_MEM: begin
                if (dec_cls == CL_STORE && dmem_ack_i) begin
                    pc_we_o = 1'b1;
                end
            end
            S_WB: begin
                pc_we_o = 1'b1;
                if (dec_cls == CL_JAL) begin
                    pc_sel_o = PC_REL;
                end else if (dec_cls == CL_JALR) begin
                    pc_sel_o = PC_JALR;
                end
            end
            default: ;
        endcase
    end

    assign retire = pc_we_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_RST;
            instr_r_o   <= '0;
            imem_req_o  <= 1'b0;
            imm_sel_o   <= IMM_NONE;
            alu_op_o    <= ALU_ADD;
            alu_a_sel_o <= 1'b0;
            alu_b_sel_o <= 1'b0;
            dmem_req_o  <= 1'b0;
            dmem_we_o   <= 1'b0;
            rf_we_o     <= 1'b0;
            wb_sel_o    <= WB_ALU;
            halted_o    <= 1'b0;
            illegal_o   <= 1'b0;
            instret_o   <= '0;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
            wait_cnt    <= '0;
            bus_err_o   <= 1'b0;
`endif
        end else begin
            case (state)
                S_RST: begin
                    state      <= S_FETCH;
                    imem_req_o <= 1'b1;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        instr_r_o  <= instr_w_i;
                        imem_req_o <= 1'b0;
                        imm_sel_o  <= dec_imm;
                        state      <= S_DECODE;
                    end
`ifdef MC_CTRL_MEM_TIMEOUT_EN
                    else if (wait_expired) begin
                        imem_req_o <= 1'b0;
                        halted_o   <= 1'b1;
                        bus_err_o  <= 1'b1;
                        state      <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (!dec_legal || dec_cls == CL_SYSTEM) begin
                        imm_sel_o <= IMM_NONE;
                        halted_o  <= 1'b1;
                        illegal_o <= !dec_legal;
                        state     <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                        case (dec_cls)
                            CL_BRANCH: alu_op_o <= ALU_CMP;
                            CL_LOAD, CL_STORE, CL_JALR: begin
                                alu_op_o    <= ALU_ADD;
                                alu_b_sel_o <= 1'b1;
                            end
                            CL_OP: alu_op_o <= ALU_FUNCT;
                            CL_OPIMM: begin
                                alu_op_o    <= ALU_FUNCT;
                                alu_b_sel_o <= 1'b1;
                            end
                            CL_LUI: begin
                                alu_op_o    <= ALU_PASS;
                                alu_b_sel_o <= 1'b1;
                            end
                            CL_AUIPC: begin
                                alu_op_o    <= ALU_ADD;
                                alu_a_sel_o <= 1'b1;
                                alu_b_sel_o <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    case (dec_cls)
                        CL_BRANCH: ;
                        CL_LOAD, CL_STORE: begin
                            dmem_req_o <= 1'b1;
                            dmem_we_o  <= (dec_cls == CL_STORE);
                            state      <= S_MEM;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
                            wait_cnt   <= '0;
`endif
                        end
                        default: begin
                            rf_we_o  <= rd_nz && (dec_cls != CL_FENCE);
                            wb_sel_o <= (dec_cls == CL_JAL || dec_cls == CL_JALR) ? WB_PC4 : WB_ALU;
                            state    <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (dec_cls == CL_LOAD) begin
                            rf_we_o  <= rd_nz;
                            wb_sel_o <= WB_MEM;
                            state    <= S_WB;
                        end
                    end
`ifdef MC_CTRL_MEM_TIMEOUT_EN
                    else if (wait_expired) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        halted_o   <= 1'b1;
                        bus_err_o  <= 1'b1;
                        state      <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_WB: ;
                S_TRAP: ;
                default: state <= S_TRAP;
            endcase

            // Retiring cycle: count it and start the next fetch with clean controls.
            if (retire) begin
                instret_o   <= instret_o + 32'd1;
                state       <= S_FETCH;
                imem_req_o  <= 1'b1;
                imm_sel_o   <= IMM_NONE;
                alu_op_o    <= ALU_ADD;
                alu_a_sel_o <= 1'b0;
                alu_b_sel_o <= 1'b0;
                rf_we_o     <= 1'b0;
                wb_sel_o    <= WB_ALU;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
                wait_cnt    <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl against a per-instruction reference model of the
// sequencer's observable behaviour (cycle count, strobes, mux codes, retire count).
`timescale 1ns/1ps
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] instr_w = '0;
    logic [31:0] instr_r;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_op;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        branch_taken = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halted;
    logic        illegal;
    logic [31:0] instret;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_instret = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(4), .XLEN(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_req_o     (imem_req),
        .imem_ack_i     (imem_ack),
        .instr_w_i      (instr_w),
        .instr_r_o      (instr_r),
        .imm_sel_o      (imm_sel),
        .alu_op_o       (alu_op),
        .alu_a_sel_o    (alu_a_sel),
        .alu_b_sel_o    (alu_b_sel),
        .branch_taken_i (branch_taken),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_ack_i     (dmem_ack),
        .rf_we_o        (rf_we),
        .wb_sel_o       (wb_sel),
        .pc_we_o        (pc_we),
        .pc_sel_o       (pc_sel),
        .halted_o       (halted),
        .illegal_o      (illegal),
`ifdef MC_CTRL_MEM_TIMEOUT_EN
        .bus_err_o      (bus_err),
`endif
        .instret_o      (instret)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected observable behaviour of one instruction, counted from the fetch-ack edge.
    typedef struct {
        bit trap;
        bit ill;
        int cyc;
        int imm;
        int npc;
        int pcsel;
        int nrf;
        int wb;
        int nmem;
        bit dwe;
        int aluop;
        bit asel;
        bit bchk;
        bit bsel;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input int mdly, input bit taken);
        exp_t e;
        e.trap = 0; e.ill = 0; e.cyc = 4; e.imm = 0; e.npc = 1; e.pcsel = 0;
        e.nrf = (ins[11:7] != 5'd0) ? 1 : 0;
        e.wb = 0; e.nmem = 0; e.dwe = 0; e.aluop = 0; e.asel = 0; e.bchk = 0; e.bsel = 0;
        case (ins[6:0])
            7'h37: begin e.imm = 2; e.aluop = 3; end
            7'h17: begin e.imm = 2; e.asel = 1; e.bchk = 1; e.bsel = 1; end
            7'h6f: begin e.imm = 1; e.wb = 2; e.pcsel = 1; end
            7'h67: begin e.imm = 5; e.wb = 2; e.pcsel = 2; end
            7'h63: begin e.imm = 4; e.cyc = 3; e.nrf = 0; e.pcsel = taken ? 1 : 0; e.aluop = 2; end
            7'h03: begin e.imm = 5; e.cyc = 5 + mdly; e.nmem = mdly + 1; e.wb = 1; e.bchk = 1; e.bsel = 1; end
            7'h23: begin e.imm = 3; e.cyc = 4 + mdly; e.nmem = mdly + 1; e.dwe = 1; e.nrf = 0; e.bchk = 1; e.bsel = 1; end
            7'h13: begin e.imm = 5; e.aluop = 1; end
            7'h33: e.aluop = 1;
            7'h0f: e.nrf = 0;
            7'h73: e.trap = 1;
            default: begin e.trap = 1; e.ill = 1; end
        endcase
        if (e.trap) begin
            e.cyc = 2; e.npc = 0; e.nrf = 0; e.imm = 0;
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_outputs", 32'({imem_req, dmem_req, dmem_we, rf_we, pc_we, halted, illegal,
                 imm_sel, alu_op, alu_a_sel, alu_b_sel, wb_sel, pc_sel}), 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        instr_w = $urandom;
        #1;
        check_eq("rst_state_quiet", 32'({imem_req, halted, illegal, rf_we, pc_we}), 32'd0);
        check_eq("rst_instret", instret, 32'd0);
`ifdef MC_CTRL_MEM_TIMEOUT_EN
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
`endif
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check_eq("rst_fetch_req", 32'(imem_req), 32'd1);
        check_eq("rst_ack_ignored_ir", instr_r, 32'd0);
        exp_instret = 0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fdly, input int mdly,
                             input bit taken, output bit trapped);
        exp_t e;
        int   fwait = 0, mwait = 0, start = -1, cyc = -1;
        int   npc = 0, nrf = 0, nmem = 0, pcs = 0, wb = 0, imm_err = 0;
        int   aop = 0;
        bit   dwe = 0, asel = 0, bsel = 0;
        e = model(ins, mdly, taken);
        branch_taken = taken;
        for (int k = 0; k < 200 && cyc < 0; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            instr_w  = $urandom;
            if (start < 0) begin
                if (imem_req) begin
                    if (fwait == fdly) begin
                        imem_ack = 1'b1;
                        instr_w  = ins;
                        start    = k;
                    end else begin
                        fwait++;
                    end
                end
            end else begin
                if (dmem_req) begin
                    if (mwait == mdly) dmem_ack = 1'b1;
                    else mwait++;
                end else begin
                    dmem_ack = 1'($urandom_range(0, 1));
                end
                if (!imem_req) imem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (start >= 0 && k > start) begin
                if (imem_req || halted) begin
                    cyc = k - start;
                    if (imm_sel != 3'd0) imm_err++;
                end else if (32'(imm_sel) != e.imm) begin
                    imm_err++;
                end
                if (k == start + 2) begin
                    aop = 32'(alu_op); asel = alu_a_sel; bsel = alu_b_sel;
                end
                if (pc_we) begin npc++; pcs = 32'(pc_sel); end
                if (rf_we) nrf++;
                if (wb_sel != 2'd0) wb = 32'(wb_sel);
                if (dmem_req) begin
                    nmem++;
                    if (dmem_we) dwe = 1'b1;
                end
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (cyc < 0) begin
            check_eq("instr_timeout", 32'd0, 32'd1);
            trapped = 1'b1;
            return;
        end
        if (!e.trap) exp_instret++;
        trapped = e.trap;
        check_eq("cycles", cyc, e.cyc);
        check_eq("halted", 32'(halted), 32'(e.trap));
        check_eq("illegal", 32'(illegal), 32'(e.ill));
        check_eq("imm_sel_hold", imm_err, 32'd0);
        check_eq("pc_we_count", npc, e.npc);
        check_eq("pc_sel", pcs, e.pcsel);
        check_eq("rf_we_count", nrf, e.nrf);
        check_eq("wb_sel", wb, e.wb);
        check_eq("dmem_req_cycles", nmem, e.nmem);
        check_eq("dmem_we", 32'(dwe), 32'(e.dwe));
        check_eq("instret", instret, exp_instret);
        check_eq("ir", instr_r, ins);
        if (!e.trap) begin
            check_eq("alu_op", aop, e.aluop);
            check_eq("alu_a_sel", 32'(asel), 32'(e.asel));
            if (e.bchk) check_eq("alu_b_sel", 32'(bsel), 32'(e.bsel));
        end
    endtask

    task automatic post_trap();
        int bad = 0;
        repeat (4) begin
            @(negedge clk);
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            instr_w  = $urandom;
            #1;
            if ({imem_req, dmem_req, dmem_we, rf_we, pc_we} != 5'd0 || !halted) bad++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check_eq("trap_absorbing", bad, 32'd0);
        check_eq("trap_instret", instret, exp_instret);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  opcs [11];
        logic [31:0] ins;
        bit          tr;
        opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};

        do_reset();

        run_instr(32'h00500093, 2, 0, 1'b0, tr);
        run_instr(32'h00000463, 0, 0, 1'b1, tr);
        run_instr(32'h00112223, 0, 3, 1'b0, tr);
        run_instr(32'h00002003, 1, 1, 1'b0, tr);
        run_instr(32'h0000007F, 0, 0, 1'b0, tr);
        if (tr) post_trap();
        do_reset();
        run_instr(32'h00000073, 1, 0, 1'b0, tr);
        if (tr) post_trap();
        do_reset();

        for (int i = 0; i < 180; i++) begin
            int sel;
            sel = $urandom_range(0, 12);
            ins = $urandom;
            if (sel < 11) ins[6:0] = opcs[sel];
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), tr);
            if (tr) begin
                post_trap();
                do_reset();
            end
        end

`ifdef MC_CTRL_MEM_TIMEOUT_EN
        begin
            int w = 0;
            do_reset();
            for (int k = 0; k < 20 && !halted; k++) begin
                @(negedge clk);
                #1;
                if (!halted) w++;
            end
            check_eq("timeout_wait_cycles", w + 1, 32'd4);
            check_eq("timeout_bus_err", 32'(bus_err), 32'd1);
            check_eq("timeout_halted", 32'(halted), 32'd1);
            do_reset();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
